spi_flash_ctrl: RTL

SPI_FLASH_CTRL -- requirements
Module: spi_flash_ctrl

---
 rtl/spi_flash_pkg.sv | 23 ++
 rtl/spi_flash_shifter.sv | 80 ++++++++
 rtl/spi_flash_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, controller state encoding and byte-order helper for the
// SPI flash controller.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    CS_GAP   = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Flash bytes travel lowest byte first; this reorders a word for that.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 serialiser: generates SCK and shifts a left-aligned TX word out
// MSB first while sampling MISO; done pulses in the cycle of the last fall.
module spi_flash_shifter
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  frame_len,
  input  logic [63:0] tx_word,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_word,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        active;
  logic        sck_q;
  logic        mosi_q;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] tx_sr;
  logic [31:0] rx_sr;
  logic        half_end;
  logic        last_bit;

  assign half_end = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == (frame_len - 7'd1));
  assign done     = active && half_end && sck_q && last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else if (start) begin
      // First bit goes out now, a full half period ahead of the first rise.
      active  <= 1'b1;
      sck_q   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      mosi_q  <= tx_word[63];
      tx_sr   <= {tx_word[62:0], 1'b0};
      rx_sr   <= '0;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_sr <= {rx_sr[30:0], miso};
        end else begin
          sck_q <= 1'b0;
          if (last_bit) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
            mosi_q  <= tx_sr[63];
            tx_sr   <= {tx_sr[62:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign rx_word = rx_sr;

endmodule

// File: rtl/spi_flash_ctrl.sv
// Word-access SPI NOR flash controller: READ (0x03) for loads, WREN + page
// program (0x02) for full-word stores; malformed accesses fail without traffic.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output state_e      dbg_state
);

  // Handshake: a request is taken in the cycle req_i=1 meets gnt_o=1 (IDLE
  // only); exactly one rvalid_o pulse, carrying rdata_o/err_o, ends it.

  localparam logic [8:0] WAIT_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_e      state, next_state;
  logic [8:0]  cnt;
  logic        cs_n_q;
  logic [23:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        wren_frame;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        bad_req;
  logic        start_shift;
  logic [6:0]  frame_len;
  logic [63:0] tx_word;
  logic [31:0] rx_word;
  logic        sh_done;

  assign accept  = (state == IDLE) && req_i && !rst;
  assign bad_req = (addr_i[1:0] != 2'b00) || (addr_i[31:24] != 8'h00) ||
                   (we_i && (be_i != 4'hF));

  always_comb begin
    next_state  = state;
    start_shift = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) next_state = bad_req ? DONE : CS_SETUP;
      end
      CS_SETUP: begin
        if (cnt == WAIT_LAST) begin
          next_state  = SHIFT;
          start_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (sh_done) next_state = CS_HOLD;
      end
      CS_HOLD: begin
        if (cnt == WAIT_LAST) next_state = wren_frame ? CS_GAP : DONE;
      end
      CS_GAP: begin
        if (cnt == GAP_LAST) next_state = CS_SETUP;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The write-enable frame precedes the program frame of a store.
  always_comb begin
    frame_len = 7'd64;
    tx_word   = {CMD_READ, addr_q, 32'h0};
    if (wren_frame) begin
      frame_len = 7'd8;
      tx_word   = {CMD_WREN, 56'h0};
    end else if (we_q) begin
      tx_word   = {CMD_PP, addr_q, bswap32(wdata_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cs_n_q     <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wren_frame <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state  <= next_state;
      cnt    <= (next_state != state) ? 9'd0 : cnt + 9'd1;
      cs_n_q <= !(next_state inside {CS_SETUP, SHIFT, CS_HOLD});
      if (accept) begin
        addr_q     <= addr_i[23:0];
        we_q       <= we_i;
        wdata_q    <= wdata_i;
        wren_frame <= we_i && !bad_req;
        err_q      <= bad_req;
        rdata_q    <= '0;
      end
      if ((state == CS_HOLD) && (next_state == CS_GAP)) wren_frame <= 1'b0;
      if (sh_done && !we_q) rdata_q <= bswap32(rx_word);
    end
  end

  spi_flash_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (start_shift),
    .frame_len (frame_len),
    .tx_word   (tx_word),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .rx_word   (rx_word),
    .done      (sh_done)
  );

  assign gnt_o     = accept;
  assign rvalid_o  = (state == DONE) && !rst;
  assign err_o     = rvalid_o && err_q;
  assign rdata_o   = rvalid_o ? rdata_q : 32'h0;
  assign spi_cs_n  = cs_n_q;
  assign dbg_state = state;

endmodule
